// File: rtl/router_port_hs.sv
`default_nettype none
//==============================================================================
// Module   : router_port_hs
// Brief    : Bidirectional router port. Valid/ready handshakes on all four
//            streams, one first-word-fall-through FIFO per direction and a
//            drain-before-turnaround state machine selecting the active
//            direction (1 = ingress local->bus, 0 = egress bus->local).
// Revision : 1.0 - initial release
//==============================================================================
module router_port_hs #(
    parameter int PORT_ID    = 0,
    parameter int DWIDTH     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter bit RESET_DIR  = 1'b1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              dir_req,
    output logic                              dir_active,
    output logic                              turn_busy,
    input  logic [DWIDTH-1:0]                 in_s_data,
    input  logic                              in_s_valid,
    output logic                              in_s_ready,
    output logic [DWIDTH-1:0]                 in_m_data,
    output logic                              in_m_valid,
    input  logic                              in_m_ready,
    input  logic [DWIDTH-1:0]                 out_s_data,
    input  logic                              out_s_valid,
    output logic                              out_s_ready,
    output logic [DWIDTH-1:0]                 out_m_data,
    output logic                              out_m_valid,
    input  logic                              out_m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   in_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   out_count,
    output logic                              in_almost_full,
    output logic                              out_almost_full
);

    localparam int              c_PW   = $clog2(FIFO_DEPTH);
    localparam int              c_CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_AF   = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [1:0] c_ST_ING   = 2'd0;
    localparam logic [1:0] c_ST_EGR   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_TURN  = 2'd3;
    localparam logic [1:0] c_ST_RESET = RESET_DIR ? c_ST_ING : c_ST_EGR;

    // Elaboration-time parameter sanity checks
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("router_port_hs: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > FIFO_DEPTH)) begin : g_bad_af_level
        $error("router_port_hs: AF_LEVEL must lie in 1..FIFO_DEPTH");
    end
    if (PORT_ID < 0) begin : g_bad_port_id
        $error("router_port_hs: PORT_ID must be non-negative");
    end

    logic [1:0]        r_state;
    logic              r_dir;

    logic [DWIDTH-1:0] r_in_mem  [FIFO_DEPTH];
    logic [c_PW-1:0]   r_in_wr;
    logic [c_PW-1:0]   r_in_rd;
    logic [c_CW-1:0]   r_in_count;

    logic [DWIDTH-1:0] r_out_mem [FIFO_DEPTH];
    logic [c_PW-1:0]   r_out_wr;
    logic [c_PW-1:0]   r_out_rd;
    logic [c_CW-1:0]   r_out_count;

    logic w_ing, w_egr, w_drain_in, w_drain_out;
    logic w_in_push, w_in_pop, w_out_push, w_out_pop;
    logic [c_CW-1:0] w_old_count;
    logic            w_old_pop;
    logic            w_old_empty_next;

    // Which side of each FIFO is open in the current state. During DRAIN only
    // the m-side of the old direction stays open; TURN closes everything.
    assign w_ing       = (r_state == c_ST_ING);
    assign w_egr       = (r_state == c_ST_EGR);
    assign w_drain_in  = (r_state == c_ST_DRAIN) &&  r_dir;
    assign w_drain_out = (r_state == c_ST_DRAIN) && !r_dir;

    // s_ready depends only on registered state (never on m_ready), so a full
    // FIFO refuses a push even on the cycle it pops. Gating with rstn keeps
    // every ready low while reset is held.
    assign in_s_ready  = rstn && w_ing && (r_in_count  != c_FULL);
    assign out_s_ready = rstn && w_egr && (r_out_count != c_FULL);

    assign in_m_valid  = (w_ing || w_drain_in)  && (r_in_count  != '0);
    assign out_m_valid = (w_egr || w_drain_out) && (r_out_count != '0);

    // Head is shown only while occupied so an emptied FIFO never exposes stale data
    assign in_m_data  = (r_in_count  != '0) ? r_in_mem[r_in_rd]   : '0;
    assign out_m_data = (r_out_count != '0) ? r_out_mem[r_out_rd] : '0;

    assign w_in_push  = in_s_valid  && in_s_ready;
    assign w_in_pop   = in_m_valid  && in_m_ready;
    assign w_out_push = out_s_valid && out_s_ready;
    assign w_out_pop  = out_m_valid && out_m_ready;

    assign in_count        = r_in_count;
    assign out_count       = r_out_count;
    assign in_almost_full  = (r_in_count  >= c_AF);
    assign out_almost_full = (r_out_count >= c_AF);

    assign dir_active = r_dir;
    assign turn_busy  = (r_state == c_ST_DRAIN) || (r_state == c_ST_TURN);

    // The old FIFO counts as empty on the cycle its last entry pops
    assign w_old_count      = r_dir ? r_in_count : r_out_count;
    assign w_old_pop        = r_dir ? w_in_pop   : w_out_pop;
    assign w_old_empty_next = (w_old_count == '0) || ((w_old_count == c_ONE) && w_old_pop);

    // Ingress FIFO storage (no reset: contents are unreachable while count is 0)
    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wr] <= in_s_data;
        end
    end

    // Ingress FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_wr    <= '0;
            r_in_rd    <= '0;
            r_in_count <= '0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
            if (w_in_pop)  r_in_rd <= r_in_rd + 1'b1;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_count <= r_in_count + 1'b1;
                2'b01:   r_in_count <= r_in_count - 1'b1;
                default: r_in_count <= r_in_count;
            endcase
        end
    end

    // Egress FIFO storage
    always_ff @(posedge clk) begin
        if (w_out_push) begin
            r_out_mem[r_out_wr] <= out_s_data;
        end
    end

    // Egress FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_wr    <= '0;
            r_out_rd    <= '0;
            r_out_count <= '0;
        end else begin
            if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
            if (w_out_pop)  r_out_rd <= r_out_rd + 1'b1;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_count <= r_out_count + 1'b1;
                2'b01:   r_out_count <= r_out_count - 1'b1;
                default: r_out_count <= r_out_count;
            endcase
        end
    end

    // Direction state machine: drain the old FIFO, one idle cycle, then switch.
    // An early return of dir_req during DRAIN takes priority over completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_RESET;
            r_dir   <= RESET_DIR;
        end else begin
            case (r_state)
                c_ST_ING: begin
                    if (!dir_req) r_state <= c_ST_DRAIN;
                end
                c_ST_EGR: begin
                    if (dir_req) r_state <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    if (dir_req == r_dir) begin
                        r_state <= r_dir ? c_ST_ING : c_ST_EGR;
                    end else if (w_old_empty_next) begin
                        r_state <= c_ST_TURN;
                    end
                end
                c_ST_TURN: begin
                    r_state <= dir_req ? c_ST_ING : c_ST_EGR;
                    r_dir   <= dir_req;
                end
                default: begin
                    r_state <= c_ST_RESET;
                    r_dir   <= RESET_DIR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_port_hs.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_router_port_hs
// Brief    : Self-checking bench for router_port_hs: directed vector table,
//            hand-written corner sequences and randomized traffic compared
//            against a queue-based behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_router_port_hs;

    localparam int  DW    = 8;
    localparam int  DEPTH = 8;
    localparam int  AF    = DEPTH - 2;
    localparam int  CW    = $clog2(DEPTH + 1);
    localparam bit  RDIR  = 1'b1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          dir_req = 1'b1;
    logic          dir_active, turn_busy;
    logic [DW-1:0] in_s_data = '0;
    logic          in_s_valid = 1'b0;
    logic          in_s_ready;
    logic [DW-1:0] in_m_data;
    logic          in_m_valid;
    logic          in_m_ready = 1'b0;
    logic [DW-1:0] out_s_data = '0;
    logic          out_s_valid = 1'b0;
    logic          out_s_ready;
    logic [DW-1:0] out_m_data;
    logic          out_m_valid;
    logic          out_m_ready = 1'b0;
    logic [CW-1:0] in_count, out_count;
    logic          in_almost_full, out_almost_full;

    router_port_hs #(
        .PORT_ID(3), .DWIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF), .RESET_DIR(RDIR)
    ) dut (
        .clk(clk), .rstn(rstn), .dir_req(dir_req), .dir_active(dir_active), .turn_busy(turn_busy),
        .in_s_data(in_s_data), .in_s_valid(in_s_valid), .in_s_ready(in_s_ready),
        .in_m_data(in_m_data), .in_m_valid(in_m_valid), .in_m_ready(in_m_ready),
        .out_s_data(out_s_data), .out_s_valid(out_s_valid), .out_s_ready(out_s_ready),
        .out_m_data(out_m_data), .out_m_valid(out_m_valid), .out_m_ready(out_m_ready),
        .in_count(in_count), .out_count(out_count),
        .in_almost_full(in_almost_full), .out_almost_full(out_almost_full)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = settled in m_dir, 1 = draining m_dir's FIFO, 2 = idle turn cycle
    logic [DW-1:0] mq_in[$];
    logic [DW-1:0] mq_out[$];
    bit            m_dir;
    int            m_phase;

    function automatic bit e_isr();
        return rstn && (m_phase == 0) && m_dir && (mq_in.size() < DEPTH);
    endfunction
    function automatic bit e_osr();
        return rstn && (m_phase == 0) && !m_dir && (mq_out.size() < DEPTH);
    endfunction
    function automatic bit e_imv();
        return (m_phase != 2) && m_dir && (mq_in.size() > 0);
    endfunction
    function automatic bit e_omv();
        return (m_phase != 2) && !m_dir && (mq_out.size() > 0);
    endfunction
    function automatic logic [DW-1:0] e_imd();
        return (mq_in.size() > 0) ? mq_in[0] : '0;
    endfunction
    function automatic logic [DW-1:0] e_omd();
        return (mq_out.size() > 0) ? mq_out[0] : '0;
    endfunction

    task automatic model_reset();
        mq_in.delete();
        mq_out.delete();
        m_dir   = RDIR;
        m_phase = 0;
    endtask

    task automatic model_advance();
        bit iu, ip, ou, op;
        iu = e_isr() && in_s_valid;
        ip = e_imv() && in_m_ready;
        ou = e_osr() && out_s_valid;
        op = e_omv() && out_m_ready;
        if (ip) void'(mq_in.pop_front());
        if (iu) mq_in.push_back(in_s_data);
        if (op) void'(mq_out.pop_front());
        if (ou) mq_out.push_back(out_s_data);
        case (m_phase)
            0: if (dir_req != m_dir) m_phase = 1;
            1: begin
                if (dir_req == m_dir) m_phase = 0;
                else if ((m_dir ? mq_in.size() : mq_out.size()) == 0) m_phase = 2;
            end
            default: begin
                m_dir   = dir_req;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_in_s_ready"},   32'(in_s_ready),      32'(e_isr()));
        chk({tag, "_in_m_valid"},   32'(in_m_valid),      32'(e_imv()));
        chk({tag, "_in_m_data"},    32'(in_m_data),       32'(e_imd()));
        chk({tag, "_in_count"},     32'(in_count),        32'(mq_in.size()));
        chk({tag, "_in_af"},        32'(in_almost_full),  32'(mq_in.size() >= AF));
        chk({tag, "_out_s_ready"},  32'(out_s_ready),     32'(e_osr()));
        chk({tag, "_out_m_valid"},  32'(out_m_valid),     32'(e_omv()));
        chk({tag, "_out_m_data"},   32'(out_m_data),      32'(e_omd()));
        chk({tag, "_out_count"},    32'(out_count),       32'(mq_out.size()));
        chk({tag, "_out_af"},       32'(out_almost_full), 32'(mq_out.size() >= AF));
        chk({tag, "_dir_active"},   32'(dir_active),      32'(m_dir));
        chk({tag, "_turn_busy"},    32'(turn_busy),       32'(m_phase != 0));
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge
    task automatic cycle_pre(input string tag);
        @(negedge clk);
        check_outputs(tag);
    endtask
    task automatic cycle_post();
        model_advance();
        @(posedge clk);
        #1;
    endtask
    task automatic cycle(input string tag);
        cycle_pre(tag);
        cycle_post();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int dreq, isv, isd, imr, osv, osd, omr;
        int isr, imv, imd, icnt, osr, omv, omd, ocnt, dir, busy;
    } vec_t;
    vec_t vecs[15];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int accepted;
        int sent;
        int guard;
        logic [DW-1:0] rcv[$];

        // dreq isv isd  imr osv osd  omr | isr imv imd  icnt osr omv omd  ocnt dir busy
        vecs[0]  = '{1, 1, 'hA1, 0, 0, 0,    0,  1, 0, 0,    0, 0, 0, 0,    0, 1, 0};
        vecs[1]  = '{1, 1, 'hA2, 0, 0, 0,    0,  1, 1, 'hA1, 1, 0, 0, 0,    0, 1, 0};
        vecs[2]  = '{1, 1, 'hA3, 0, 0, 0,    0,  1, 1, 'hA1, 2, 0, 0, 0,    0, 1, 0};
        vecs[3]  = '{0, 0, 0,    0, 0, 0,    0,  1, 1, 'hA1, 3, 0, 0, 0,    0, 1, 0};
        vecs[4]  = '{0, 1, 'hFF, 1, 0, 0,    0,  0, 1, 'hA1, 3, 0, 0, 0,    0, 1, 1};
        vecs[5]  = '{0, 1, 'hFF, 1, 0, 0,    0,  0, 1, 'hA2, 2, 0, 0, 0,    0, 1, 1};
        vecs[6]  = '{0, 1, 'hFF, 1, 0, 0,    0,  0, 1, 'hA3, 1, 0, 0, 0,    0, 1, 1};
        vecs[7]  = '{0, 0, 0,    1, 1, 'hB1, 0,  0, 0, 0,    0, 0, 0, 0,    0, 1, 1};
        vecs[8]  = '{0, 0, 0,    0, 1, 'hB1, 0,  0, 0, 0,    0, 1, 0, 0,    0, 0, 0};
        vecs[9]  = '{0, 0, 0,    0, 0, 0,    1,  0, 0, 0,    0, 1, 1, 'hB1, 1, 0, 0};
        vecs[10] = '{0, 0, 0,    0, 0, 0,    1,  0, 0, 0,    0, 1, 0, 0,    0, 0, 0};
        vecs[11] = '{1, 0, 0,    0, 0, 0,    0,  0, 0, 0,    0, 1, 0, 0,    0, 0, 0};
        vecs[12] = '{1, 0, 0,    0, 0, 0,    0,  0, 0, 0,    0, 0, 0, 0,    0, 0, 1};
        vecs[13] = '{1, 0, 0,    0, 0, 0,    0,  0, 0, 0,    0, 0, 0, 0,    0, 0, 1};
        vecs[14] = '{1, 0, 0,    0, 0, 0,    0,  1, 0, 0,    0, 0, 0, 0,    0, 1, 0};

        // ---- reset state ----
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dir_active", 32'(dir_active), 32'(RDIR));
        chk("rst_in_s_ready", 32'(in_s_ready), 32'(0));
        chk("rst_turn_busy",  32'(turn_busy),  32'(0));
        chk("rst_in_count",   32'(in_count),   32'(0));
        chk("rst_out_m_data", 32'(out_m_data), 32'(0));
        @(posedge clk);
        #1 rstn = 1'b1;

        // ---- turnaround with data, empty turnaround back ----
        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("row%0d", i);
            dir_req     = vecs[i].dreq[0];
            in_s_valid  = vecs[i].isv[0];
            in_s_data   = 8'(vecs[i].isd);
            in_m_ready  = vecs[i].imr[0];
            out_s_valid = vecs[i].osv[0];
            out_s_data  = 8'(vecs[i].osd);
            out_m_ready = vecs[i].omr[0];
            cycle_pre(t);
            chk({t, "_tbl_isr"},  32'(in_s_ready),  32'(vecs[i].isr));
            chk({t, "_tbl_imv"},  32'(in_m_valid),  32'(vecs[i].imv));
            chk({t, "_tbl_imd"},  32'(in_m_data),   32'(vecs[i].imd));
            chk({t, "_tbl_icnt"}, 32'(in_count),    32'(vecs[i].icnt));
            chk({t, "_tbl_osr"},  32'(out_s_ready), 32'(vecs[i].osr));
            chk({t, "_tbl_omv"},  32'(out_m_valid), 32'(vecs[i].omv));
            chk({t, "_tbl_omd"},  32'(out_m_data),  32'(vecs[i].omd));
            chk({t, "_tbl_ocnt"}, 32'(out_count),   32'(vecs[i].ocnt));
            chk({t, "_tbl_dir"},  32'(dir_active),  32'(vecs[i].dir));
            chk({t, "_tbl_busy"}, 32'(turn_busy),   32'(vecs[i].busy));
            cycle_post();
        end
        in_s_valid = 1'b0; out_s_valid = 1'b0; out_m_ready = 1'b0;

        // ---- streaming 0x01..0x14 with in_m_ready high ----
        dir_req = 1'b1; in_m_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_s_valid = 1'b1;
            in_s_data  = 8'(i);
            cycle("stream");
        end
        in_s_valid = 1'b0;
        repeat (2) cycle("stream_tail");

        // ---- backpressure until full ----
        in_m_ready = 1'b0;
        in_s_valid = 1'b1;
        accepted   = 0;
        for (int k = 0; k < 12; k++) begin
            in_s_data = 8'(8'h40 + accepted);
            cycle_pre("fill");
            if (in_s_ready) accepted++;
            cycle_post();
        end
        chk("full_accepted", 32'(accepted),       32'(8));
        chk("full_count",    32'(in_count),       32'(8));
        chk("full_af",       32'(in_almost_full), 32'(1));
        in_m_ready = 1'b1;
        in_s_data  = 8'h5A;
        cycle_pre("release");
        chk("no_push_first_pop", 32'(in_s_ready), 32'(0));
        cycle_post();
        in_s_valid = 1'b0;
        repeat (9) cycle("release_drain");

        // ---- aborted turn ----
        in_m_ready = 1'b0;
        in_s_valid = 1'b1;
        in_s_data = 8'h61; cycle("abort_fill");
        in_s_data = 8'h62; cycle("abort_fill");
        in_s_valid = 1'b0;
        dir_req = 1'b0;
        cycle("abort_req");
        cycle("abort_drain");
        dir_req = 1'b1;
        cycle("abort_back");
        cycle_pre("abort_ing");
        chk("abort_busy",  32'(turn_busy),  32'(0));
        chk("abort_count", 32'(in_count),   32'(2));
        chk("abort_head",  32'(in_m_data),  32'(8'h61));
        cycle_post();
        in_m_ready = 1'b1;
        repeat (3) cycle("abort_flush");

        // ---- reset mid-operation while in egress with 5 flits queued ----
        dir_req = 1'b0;
        repeat (3) cycle("to_egr");
        out_m_ready = 1'b0;
        out_s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            out_s_data = 8'(8'h71 + i);
            cycle("egr_fill");
        end
        out_s_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_out_count", 32'(out_count),   32'(0));
        chk("arst_out_valid", 32'(out_m_valid), 32'(0));
        chk("arst_dir",       32'(dir_active),  32'(RDIR));
        chk("arst_out_ready", 32'(out_s_ready), 32'(0));
        chk("arst_in_ready",  32'(in_s_ready),  32'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        dir_req = 1'b1; out_m_ready = 1'b1; in_m_ready = 1'b1;
        repeat (4) cycle("post_rst");

        // ---- wrap-around with random in_m_ready ----
        sent = 0; guard = 0;
        rcv.delete();
        while ((sent < 3*DEPTH+3 || rcv.size() < 3*DEPTH+3) && guard < 600) begin
            in_s_valid = (sent < 3*DEPTH+3);
            in_s_data  = 8'(sent + 1);
            in_m_ready = 1'($urandom_range(0, 1));
            cycle_pre("wrap");
            if (in_s_valid && in_s_ready) sent++;
            if (in_m_valid && in_m_ready) rcv.push_back(in_m_data);
            cycle_post();
            guard++;
        end
        in_s_valid = 1'b0;
        chk("wrap_received", 32'(rcv.size()), 32'(3*DEPTH+3));
        for (int i = 0; i < rcv.size(); i++) begin
            chk($sformatf("wrap_flit%0d", i), 32'(rcv[i]), 32'(i + 1));
        end

        // ---- randomized traffic with direction changes ----
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) dir_req = ~dir_req;
            in_s_valid  = 1'($urandom_range(0, 1));
            in_s_data   = 8'($urandom);
            in_m_ready  = ($urandom_range(0, 3) != 0);
            out_s_valid = 1'($urandom_range(0, 1));
            out_s_data  = 8'($urandom);
            out_m_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
